// File: rtl/decode_stage_pkg.sv
// Shared decode-stage definitions: opcodes, control encodings, immediate
// types, the ID/EX bundle and the ALU-control helper.
package decode_stage_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH= 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] RES_ALU  = 3'b000;
    localparam logic [2:0] RES_MEM  = 3'b001;
    localparam logic [2:0] RES_PC4  = 3'b010;
    localparam logic [2:0] RES_IMM  = 3'b011;
    localparam logic [2:0] RES_PCIMM= 3'b100;

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_src_t;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu_ctrl;
        logic [2:0]  result_src;
        logic [1:0]  store_src;
        logic [2:0]  funct3;
        logic        mem_write;
        logic        reg_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic        op3;
        logic        op5;
        logic        is_load;
    } id_ex_t;

    // funct7[5] selects SUB only on R-type; SRA on both R and I shifts.
    function automatic logic [3:0] alu_decode(
        input logic [2:0] f3,
        input logic       f7b5,
        input logic       is_r
    );
        logic [3:0] a;
        case (f3)
            3'b000:  a = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/decode_stage_controller.sv
// Main decoder: opcode/funct3/funct7[5] -> datapath controls and
// immediate type. Unknown opcodes decode to an all-zero bubble.
module controller
    import decode_stage_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_ctrl,
    output logic [2:0] result_src,
    output logic [1:0] store_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src,
    output logic       branch,
    output logic       jump,
    output logic       is_load,
    output imm_src_t   imm_src
);

    always_comb begin
        alu_ctrl   = ALU_ADD;
        result_src = RES_ALU;
        store_src  = ST_SW;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        is_load    = 1'b0;
        imm_src    = IMM_I;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_ctrl  = alu_decode(funct3, funct7b5, 1'b1);
            end
            OP_I_ALU: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = alu_decode(funct3, funct7b5, 1'b0);
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                is_load    = 1'b1;
                result_src = RES_MEM;
            end
            OP_JALR: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                jump       = 1'b1;
                result_src = RES_PC4;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
                case (funct3)
                    3'b000:  store_src = ST_SB;
                    3'b001:  store_src = ST_SH;
                    default: store_src = ST_SW;
                endcase
            end
            OP_BRANCH: begin
                branch   = 1'b1;
                alu_ctrl = ALU_SUB;
                imm_src  = IMM_B;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = RES_PC4;
                imm_src    = IMM_J;
            end
            OP_LUI: begin
                reg_write  = 1'b1;
                result_src = RES_IMM;
                imm_src    = IMM_U;
            end
            OP_AUIPC: begin
                reg_write  = 1'b1;
                result_src = RES_PCIMM;
                imm_src    = IMM_U;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file: two combinational reads with write-through, one
// synchronous write. Ports: clk, reset, ra1/ra2 -> rd1/rd2, we/wa/wd.
module reg_file
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs_q [32];
    logic        wr_en;

    assign wr_en = we && (wa != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa] <= wd;
        end
    end

    // Writeback in the same cycle bypasses the array.
    always_comb begin
        if (ra1 == 5'd0)
            rd1 = '0;
        else if (wr_en && wa == ra1)
            rd1 = wd;
        else
            rd1 = regs_q[ra1];

        if (ra2 == 5'd0)
            rd2 = '0;
        else if (wr_en && wa == ra2)
            rd2 = wd;
        else
            rd2 = regs_q[ra2];
    end

endmodule

// File: rtl/decode_stage_sign_extender.sv
// Immediate generator. Ports: instr (bits 31:7), imm_src -> imm,
// sign-extended to 32 bits.
module sign_extender
    import decode_stage_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_src_t    imm_src,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_src)
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RISC-V decode stage: register file, immediate and control decode,
// and the ID/EX pipeline register (reset > flush > capture).
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic [31:0] ResultW,
    input  logic        RegWriteW,
    input  logic [4:0]  rdW,
    input  logic        Branch_or_Jump_taken,
    input  logic        id_ex_flush,
    output logic [4:0]  rs1D2H,
    output logic [4:0]  rs2D2H,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [31:0] extended_immE,
    output logic [4:0]  rdE,
    output logic [4:0]  rs1E,
    output logic [4:0]  rs2E,
    output logic [3:0]  ALUControlE,
    output logic [2:0]  ResultSrcE,
    output logic [1:0]  StoreSrcE,
    output logic [2:0]  funct3E,
    output logic        MemWriteE,
    output logic        RegWriteE,
    output logic        ALUSrcE,
    output logic        BranchE,
    output logic        JumpE,
    output logic        op3E,
    output logic        op5E,
    output logic        is_loadE
);

    id_ex_t   ex_d;
    id_ex_t   ex_q;
    imm_src_t imm_src;
    logic     flush;

    assign rs1D2H = instrD[19:15];
    assign rs2D2H = instrD[24:20];
    assign flush  = Branch_or_Jump_taken | id_ex_flush;

    reg_file u_rf (
        .clk   (clk),
        .reset (reset),
        .ra1   (instrD[19:15]),
        .ra2   (instrD[24:20]),
        .rd1   (ex_d.rd1),
        .rd2   (ex_d.rd2),
        .we    (RegWriteW),
        .wa    (rdW),
        .wd    (ResultW)
    );

    controller u_ctrl (
        .opcode     (instrD[6:0]),
        .funct3     (instrD[14:12]),
        .funct7b5   (instrD[30]),
        .alu_ctrl   (ex_d.alu_ctrl),
        .result_src (ex_d.result_src),
        .store_src  (ex_d.store_src),
        .mem_write  (ex_d.mem_write),
        .reg_write  (ex_d.reg_write),
        .alu_src    (ex_d.alu_src),
        .branch     (ex_d.branch),
        .jump       (ex_d.jump),
        .is_load    (ex_d.is_load),
        .imm_src    (imm_src)
    );

    sign_extender u_ext (
        .instr   (instrD[31:7]),
        .imm_src (imm_src),
        .imm     (ex_d.imm)
    );

    assign ex_d.pc     = PCD;
    assign ex_d.pc4    = PCPlus4D;
    assign ex_d.rd     = instrD[11:7];
    assign ex_d.rs1    = instrD[19:15];
    assign ex_d.rs2    = instrD[24:20];
    assign ex_d.funct3 = instrD[14:12];
    assign ex_d.op3    = instrD[3];
    assign ex_d.op5    = instrD[5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ex_q <= '0;
        else if (flush)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign RD1E          = ex_q.rd1;
    assign RD2E          = ex_q.rd2;
    assign PCE           = ex_q.pc;
    assign PCPlus4E      = ex_q.pc4;
    assign extended_immE = ex_q.imm;
    assign rdE           = ex_q.rd;
    assign rs1E          = ex_q.rs1;
    assign rs2E          = ex_q.rs2;
    assign ALUControlE   = ex_q.alu_ctrl;
    assign ResultSrcE    = ex_q.result_src;
    assign StoreSrcE     = ex_q.store_src;
    assign funct3E       = ex_q.funct3;
    assign MemWriteE     = ex_q.mem_write;
    assign RegWriteE     = ex_q.reg_write;
    assign ALUSrcE       = ex_q.alu_src;
    assign BranchE       = ex_q.branch;
    assign JumpE         = ex_q.jump;
    assign op3E          = ex_q.op3;
    assign op5E          = ex_q.op5;
    assign is_loadE      = ex_q.is_load;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// Inputs change 1 time unit after the rising edge; outputs checked then.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, Branch_or_Jump_taken, id_ex_flush;
    logic [4:0]  rdW;
    logic [4:0]  rs1D2H, rs2D2H, rdE, rs1E, rs2E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, extended_immE;
    logic [3:0]  ALUControlE;
    logic [2:0]  ResultSrcE, funct3E;
    logic [1:0]  StoreSrcE;
    logic        MemWriteE, RegWriteE, ALUSrcE, BranchE, JumpE;
    logic        op3E, op5E, is_loadE;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .instrD               (instrD),
        .PCD                  (PCD),
        .PCPlus4D             (PCPlus4D),
        .ResultW              (ResultW),
        .RegWriteW            (RegWriteW),
        .rdW                  (rdW),
        .Branch_or_Jump_taken (Branch_or_Jump_taken),
        .id_ex_flush          (id_ex_flush),
        .rs1D2H               (rs1D2H),
        .rs2D2H               (rs2D2H),
        .RD1E                 (RD1E),
        .RD2E                 (RD2E),
        .PCE                  (PCE),
        .PCPlus4E             (PCPlus4E),
        .extended_immE        (extended_immE),
        .rdE                  (rdE),
        .rs1E                 (rs1E),
        .rs2E                 (rs2E),
        .ALUControlE          (ALUControlE),
        .ResultSrcE           (ResultSrcE),
        .StoreSrcE            (StoreSrcE),
        .funct3E              (funct3E),
        .MemWriteE            (MemWriteE),
        .RegWriteE            (RegWriteE),
        .ALUSrcE              (ALUSrcE),
        .BranchE              (BranchE),
        .JumpE                (JumpE),
        .op3E                 (op3E),
        .op5E                 (op5E),
        .is_loadE             (is_loadE)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every E output OR-reduced: zero only if the whole bundle is zero.
    function automatic logic [31:0] all_e();
        return RD1E | RD2E | PCE | PCPlus4E | extended_immE
             | {27'd0, rdE | rs1E | rs2E}
             | {28'd0, ALUControlE} | {29'd0, ResultSrcE | funct3E}
             | {30'd0, StoreSrcE}
             | {31'd0, MemWriteE | RegWriteE | ALUSrcE | BranchE
                       | JumpE | op3E | op5E | is_loadE};
    endfunction

    initial begin
        reset = 1'b1;
        instrD = '0; PCD = '0; PCPlus4D = '0; ResultW = '0;
        RegWriteW = 1'b0; rdW = '0;
        Branch_or_Jump_taken = 1'b0; id_ex_flush = 1'b0;
        #1;
        chk("reset_all_e", all_e(), 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // write x5
        RegWriteW = 1'b1; rdW = 5'd5; ResultW = 32'h12345678;
        tick();
        // addi x1,x5,0 reads x5 from the array
        RegWriteW = 1'b0;
        instrD = 32'h00028093; PCD = 32'h1000; PCPlus4D = 32'h1004;
        #1;
        chk("rs1D2H", {27'd0, rs1D2H}, 32'd5);
        tick();
        chk("rd1_x5", RD1E, 32'h12345678);
        chk("rs1E", {27'd0, rs1E}, 32'd5);
        chk("rdE_addi", {27'd0, rdE}, 32'd1);
        chk("alusrc_addi", {31'd0, ALUSrcE}, 32'd1);
        chk("pce", PCE, 32'h1000);
        chk("pc4e", PCPlus4E, 32'h1004);

        // same-cycle write/read of x5
        RegWriteW = 1'b1; rdW = 5'd5; ResultW = 32'hCAFEBABE;
        tick();
        chk("wt_x5", RD1E, 32'hCAFEBABE);

        // write x0 must not bypass nor stick
        rdW = 5'd0; ResultW = 32'hDEADBEEF; instrD = 32'h00000093;
        tick();
        chk("x0_bypass", RD1E, 32'h0);
        RegWriteW = 1'b0;
        tick();
        chk("x0_read", RD1E, 32'h0);

        // lw x1,-4(x2) while x2 is written back
        RegWriteW = 1'b1; rdW = 5'd2; ResultW = 32'hA5A5A5A5;
        instrD = 32'hFFC12083;
        tick();
        chk("lw_imm", extended_immE, 32'hFFFFFFFC);
        chk("lw_isload", {31'd0, is_loadE}, 32'd1);
        chk("lw_res", {29'd0, ResultSrcE}, 32'd1);
        chk("lw_alusrc", {31'd0, ALUSrcE}, 32'd1);
        chk("lw_rd1_wt", RD1E, 32'hA5A5A5A5);
        chk("lw_f3", {29'd0, funct3E}, 32'd2);

        // sub x0,x1,x2
        RegWriteW = 1'b0; instrD = 32'h40208033;
        tick();
        chk("sub_alu", {28'd0, ALUControlE}, 32'd1);
        chk("sub_regw", {31'd0, RegWriteE}, 32'd1);
        chk("sub_alusrc", {31'd0, ALUSrcE}, 32'd0);
        chk("sub_res", {29'd0, ResultSrcE}, 32'd0);
        chk("sub_rd2", RD2E, 32'hA5A5A5A5);
        chk("sub_op5", {31'd0, op5E}, 32'd1);

        // beq imm -4
        instrD = 32'hFE000EE3;
        tick();
        chk("beq_br", {31'd0, BranchE}, 32'd1);
        chk("beq_imm", extended_immE, 32'hFFFFFFFC);
        chk("beq_alu", {28'd0, ALUControlE}, 32'd1);
        chk("beq_regw", {31'd0, RegWriteE}, 32'd0);

        // lui x1,0x12345
        instrD = 32'h123450B7;
        tick();
        chk("lui_imm", extended_immE, 32'h12345000);
        chk("lui_res", {29'd0, ResultSrcE}, 32'd3);
        chk("lui_regw", {31'd0, RegWriteE}, 32'd1);

        // sw x2,8(x1)
        instrD = 32'h0020A423;
        tick();
        chk("sw_mw", {31'd0, MemWriteE}, 32'd1);
        chk("sw_imm", extended_immE, 32'd8);
        chk("sw_ss", {30'd0, StoreSrcE}, 32'd0);
        chk("sw_regw", {31'd0, RegWriteE}, 32'd0);

        // sb x2,8(x1)
        instrD = 32'h00208423;
        tick();
        chk("sb_ss", {30'd0, StoreSrcE}, 32'd2);

        // jal x1,-4
        instrD = 32'hFFDFF0EF;
        tick();
        chk("jal_imm", extended_immE, 32'hFFFFFFFC);
        chk("jal_j", {31'd0, JumpE}, 32'd1);
        chk("jal_res", {29'd0, ResultSrcE}, 32'd2);
        chk("jal_op3", {31'd0, op3E}, 32'd1);

        // sra x3,x1,x2
        instrD = 32'h4020D1B3;
        tick();
        chk("sra_alu", {28'd0, ALUControlE}, 32'd9);

        // flush sources
        instrD = 32'h123450B7; PCD = 32'h2000; PCPlus4D = 32'h2004;
        Branch_or_Jump_taken = 1'b1;
        tick();
        chk("flush_bjt", all_e(), 32'h0);
        Branch_or_Jump_taken = 1'b0;
        tick();
        chk("after_flush", PCE, 32'h2000);
        id_ex_flush = 1'b1;
        tick();
        chk("flush_idex", all_e(), 32'h0);
        id_ex_flush = 1'b0;

        // reset mid-cycle, then register file cleared
        instrD = 32'h00028093;
        tick();
        chk("pre_rst_rd1", RD1E, 32'hCAFEBABE);
        #2 reset = 1'b1;
        #1;
        chk("async_rst", all_e(), 32'h0);
        Branch_or_Jump_taken = 1'b1;
        tick();
        chk("rst_hold", all_e(), 32'h0);
        Branch_or_Jump_taken = 1'b0;
        reset = 1'b0;
        tick();
        chk("rf_cleared", RD1E, 32'h0);
        chk("post_rst_regw", {31'd0, RegWriteE}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: none; data width is fixed at 32, register count at 32.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all pipeline state.
REQ-004 instrD  in  32  instruction word in decode.
REQ-005 PCD, PCPlus4D  in  32 each  PC and PC+4 of the decode instruction.
REQ-006 ResultW  in  32, RegWriteW  in  1, rdW  in  5  writeback data, enable and destination.
REQ-007 Branch_or_Jump_taken, id_ex_flush  in  1 each  ID/EX flush requests.
REQ-008 rs1D2H, rs2D2H  out  5 each  combinational instrD[19:15] and instrD[24:20], for the hazard unit.
REQ-009 RD1E, RD2E, PCE, PCPlus4E, extended_immE  out  32 each  registered operands, PCs and immediate.
REQ-010 rdE, rs1E, rs2E  out  5 each  registered instrD[11:7], [19:15], [24:20].
REQ-011 ALUControlE  out  4; ResultSrcE  out  3; StoreSrcE  out  2; funct3E  out  3.
REQ-012 MemWriteE, RegWriteE, ALUSrcE, BranchE, JumpE, op3E, op5E, is_loadE  out  1 each  registered controls.

Function
REQ-013 Register file: 32x32, two combinational reads, one write on the clk rise when RegWriteW=1 and rdW!=0; x0 always reads 0.
REQ-014 Write-through: if RegWriteW=1, rdW!=0 and rdW equals a read address in the same cycle, that read returns ResultW.
REQ-015 Immediate generation, sign-extended to 32 bits: I = instr[31:20]; S = {instr[31:25], instr[11:7]}; B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}; U = {instr[31:12], 12'b0}.
REQ-016 Opcode decode selects the immediate type: R, I-ALU, load, JALR, store, branch, JAL, LUI, AUIPC.
REQ-017 ALUControl codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
REQ-018 ALUControl selection: SUB only for R-type with funct7[5]=1 and funct3=000; SRA when funct7[5]=1 and funct3=101 (R or I); branches use SUB; load/store/JALR/AUIPC use ADD.
REQ-019 ResultSrc codes: 000 ALU, 001 load data, 010 PC+4 (JAL/JALR), 011 immediate (LUI), 100 PC+imm (AUIPC).
REQ-020 RegWrite=1 for R, I-ALU, load, JAL, JALR, LUI, AUIPC.
REQ-021 MemWrite=1 only for store; StoreSrc from funct3: 00 SW, 01 SH, 10 SB.
REQ-022 ALUSrc=1 for I-ALU, load, store, JALR.
REQ-023 Branch=1 for opcode 1100011; Jump=1 for JAL and JALR; is_load=1 for opcode 0000011.
REQ-024 op3=instr[3], op5=instr[5], funct3=instr[14:12], passed through unchanged.
REQ-025 Unrecognised opcode: all control outputs 0 (bubble).
REQ-026 ID/EX register: 1-cycle latency; every E output is the decode value captured at the clk rise.
REQ-027 Edge priority: reset > flush (Branch_or_Jump_taken OR id_ex_flush) > capture.
REQ-028 Flush loads all-zero into every E output, including PCs, rd/rs fields and data.

Reset
REQ-029 Asynchronous reset drives every E output to 0 immediately and holds it while asserted.
REQ-030 Reset clears all 32 registers to 0.
REQ-031 Registers also power up at 0.
REQ-032 A flush arriving during reset has no additional effect.

Structure
REQ-033 Shared package holds opcode, ALUControl, ResultSrc, StoreSrc and immediate-type constants.
REQ-034 Sub-modules: reg_file, sign_extender, controller (combinational); ID/EX register in the top.

Verification
REQ-035 Write x5=0x12345678 via WB, then read rs1=5 -> RD1E=0x12345678 one cycle later; same-cycle write/read of x5 -> new value; write x0 -> reads 0.
REQ-036 instrD=0x40208033 (sub x0,x1,x2) -> ALUControlE=0001, RegWriteE=1, ALUSrcE=0, ResultSrcE=000.
REQ-037 instrD=0xFFC12083 (lw x1,-4(x2)) -> extended_immE=0xFFFFFFFC, is_loadE=1, ResultSrcE=001, ALUSrcE=1.
REQ-038 instrD=0xFE000EE3 (beq, imm -4) -> BranchE=1, extended_immE=0xFFFFFFFC, ALUControlE=0001, RegWriteE=0.
REQ-039 Valid instruction with Branch_or_Jump_taken=1 at the edge -> all E outputs 0; reset asserted mid-cycle -> outputs 0 before the next edge.
REQ-040 instrD=0x123450B7 (lui x1) -> extended_immE=0x12345000, ResultSrcE=011, RegWriteE=1.
